// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader
// Drains bytes from a first-word-fall-through FIFO and shifts each one out as
// an asynchronous UART frame: one start bit (low), DATA_WIDTH data bits LSB
// first, then STOP_BITS stop bits (high). One byte is popped per frame.
//
// Parameters:
//   DATA_WIDTH - bits per character (also FIFO read-data width)
//   DIVISOR    - clock cycles per bit time (>= 2)
//   STOP_BITS  - 1 or 2
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active-high reset
//   tx_en      - allows new frames to start; a running frame always completes
//   fifo_dout  - FIFO head word, valid while fifo_empty is low
//   fifo_empty - FIFO empty flag
//   fifo_pop   - one-cycle pop strobe (combinational)
//   tx         - serial line, registered, idle-high
//   busy       - registered, high while a frame is on the line
//   tx_done    - registered one-cycle pulse in the final cycle of a frame

module uart_tx_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIVISOR    = 217,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned BAUD_W = $clog2(DIVISOR);
  localparam int unsigned BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(DIVISOR - 2);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q,  baud_d;
  logic [BIT_W-1:0]        bit_q,   bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    tx_q,    tx_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        // Gating on reset keeps the strobe low while reset is held, since
        // the state register already reads IDLE during reset.
        if (tx_en && !fifo_empty && !reset) begin
          fifo_pop = 1'b1;
          state_d  = START;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
        end
      end

      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        // tx_done is registered, so it is armed one cycle before the last
        // cycle of the final stop bit.
        if (baud_q == BAUD_PRE && bit_q == STOP_LAST) begin
          done_d = 1'b1;
        end
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Bench for uart_tx_fifo_reader: instance A (DIVISOR=4, 1 stop bit) and
// instance B (DIVISOR=3, 2 stop bits) share clock, reset and tx_en. Each has
// its own FIFO model. Bytes are pushed to an expected queue when loaded into
// the FIFO model; each tx_done triggers a decode of the recorded line and a
// comparison against the queue head.

module tb_uart_tx_fifo_reader;

  localparam int W  = 8;
  localparam int DA = 4;
  localparam int SA = 1;
  localparam int DB = 3;
  localparam int SB = 2;
  localparam int M  = 8191;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_en = 1'b1;
  logic [7:0] dout_a = '0;
  logic [7:0] dout_b = '0;
  logic empty_a = 1'b1;
  logic empty_b = 1'b1;
  logic pop_a, tx_a, busy_a, done_a;
  logic pop_b, tx_b, busy_b, done_b;

  uart_tx_fifo_reader #(.DATA_WIDTH(W), .DIVISOR(DA), .STOP_BITS(SA)) dut_a (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_dout(dout_a),
    .fifo_empty(empty_a), .fifo_pop(pop_a), .tx(tx_a), .busy(busy_a),
    .tx_done(done_a)
  );

  uart_tx_fifo_reader #(.DATA_WIDTH(W), .DIVISOR(DB), .STOP_BITS(SB)) dut_b (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_dout(dout_b),
    .fifo_empty(empty_b), .fifo_pop(pop_b), .tx(tx_b), .busy(busy_b),
    .tx_done(done_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] fq_a[$];
  logic [7:0] fq_b[$];
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int popq_a[$];
  int popq_b[$];
  int pop_cnt[2];
  int done_cnt[2];
  int last_pop[2];
  int last_done[2];
  logic pop_prev[2];
  logic txh[2][8192];
  logic bsh[2][8192];

  task automatic drive_fifo();
    empty_a = (fq_a.size() == 0);
    dout_a  = empty_a ? 8'h00 : fq_a[0];
    empty_b = (fq_b.size() == 0);
    dout_b  = empty_b ? 8'h00 : fq_b[0];
  endtask

  task automatic push_a(input logic [7:0] b);
    fq_a.push_back(b);
    exp_a.push_back(b);
  endtask

  task automatic push_b(input logic [7:0] b);
    fq_b.push_back(b);
    exp_b.push_back(b);
  endtask

  task automatic frame_check(input int u, input int e);
    int d = (u == 0) ? DA : DB;
    int s = (u == 0) ? SA : SB;
    int t;
    logic [10:0] obs;
    logic [10:0] expw;
    logic [7:0] b;
    bit glitch;
    t = e - (W + 1 + s) * d;
    checks++;
    if (last_pop[u] !== t) begin
      errors++;
      $display("FAIL frame_start_%0d: pop cycle %0d, required %0d", u, last_pop[u], t);
    end
    obs = '0;
    glitch = 1'b0;
    for (int k = 0; k < W + 1 + s; k++) begin
      obs[k] = txh[u][(t + 1 + k * d) & M];
      for (int j = 0; j < d; j++) begin
        if (txh[u][(t + 1 + k * d + j) & M] !== obs[k] ||
            bsh[u][(t + 1 + k * d + j) & M] !== 1'b1)
          glitch = 1'b1;
      end
    end
    checks++;
    if ((u == 0 && exp_a.size() == 0) || (u == 1 && exp_b.size() == 0)) begin
      errors++;
      $display("FAIL frame_unexpected_%0d: frame 0x%03h at cycle %0d, required none", u, obs, e);
    end else begin
      b = (u == 0) ? exp_a.pop_front() : exp_b.pop_front();
      expw = '0;
      expw[8:1] = b;
      expw[9] = 1'b1;
      if (s == 2) expw[10] = 1'b1;
      if (glitch || obs !== expw) begin
        errors++;
        $display("FAIL frame_data_%0d: line 0x%03h unstable=%0d, required 0x%03h", u, obs, glitch, expw);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (pop_prev[0]) void'(fq_a.pop_front());
    if (pop_prev[1]) void'(fq_b.pop_front());
    drive_fifo();
  endtask

  task automatic sample();
    @(negedge clk);
    txh[0][cyc & M] = tx_a;
    bsh[0][cyc & M] = busy_a;
    txh[1][cyc & M] = tx_b;
    bsh[1][cyc & M] = busy_b;
    pop_prev[0] = pop_a;
    pop_prev[1] = pop_b;
    if (pop_a === 1'b1) begin
      pop_cnt[0]++;
      last_pop[0] = cyc;
      popq_a.push_back(cyc);
    end
    if (pop_b === 1'b1) begin
      pop_cnt[1]++;
      last_pop[1] = cyc;
      popq_b.push_back(cyc);
    end
    if (done_a === 1'b1) begin
      done_cnt[0]++;
      last_done[0] = cyc;
      frame_check(0, cyc);
    end
    if (done_b === 1'b1) begin
      done_cnt[1]++;
      last_done[1] = cyc;
      frame_check(1, cyc);
    end
  endtask

  task automatic cycle();
    tick();
    sample();
  endtask

  task automatic run_until_done(input int u, input int target, input int bound, output bit ok);
    int n = 0;
    while (done_cnt[u] < target && n < bound) begin
      cycle();
      n++;
    end
    ok = (done_cnt[u] >= target);
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b1;
    drive_fifo();
    repeat (3) cycle();
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || pop_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: tx=%b busy=%b pop=%b done=%b, required 1 0 0 0", tx_a, busy_a, pop_a, done_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || pop_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: tx=%b busy=%b pop=%b done=%b, required 1 0 0 0", tx_b, busy_b, pop_b, done_b);
    end
    tick();
    reset = 1'b0;
    sample();
    repeat (50) begin
      cycle();
      if (pop_a !== 1'b0 || tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_empty: %0d bad cycles, required 0", bad);
    end
  endtask

  task automatic test_single_byte();
    logic [9:0] seq;
    int t;
    int base_pop;
    int base_done;
    bit ok;
    seq = 10'b1101001010;
    base_pop = pop_cnt[0];
    base_done = done_cnt[0];
    tick();
    push_a(8'hA5);
    drive_fifo();
    sample();
    t = cyc;
    checks++;
    if (pop_a !== 1'b1) begin
      errors++;
      $display("FAIL pop_latency: pop=%b, required 1", pop_a);
    end
    cycle();
    checks++;
    if (pop_a !== 1'b0 || busy_a !== 1'b1 || tx_a !== 1'b0) begin
      errors++;
      $display("FAIL start_bit: pop=%b busy=%b tx=%b, required 0 1 0", pop_a, busy_a, tx_a);
    end
    run_until_done(0, base_done + 1, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_done_timeout: done count %0d, required %0d", done_cnt[0], base_done + 1);
    end
    checks++;
    if (last_done[0] - t != 40) begin
      errors++;
      $display("FAIL single_done_cycle: T+%0d, required T+40", last_done[0] - t);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (txh[0][(t + 3 + 4 * k) & M] !== seq[k]) begin
        errors++;
        $display("FAIL single_bit_%0d: tx=%b, required %b", k, txh[0][(t + 3 + 4 * k) & M], seq[k]);
      end
    end
    cycle();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: busy=%b done=%b, required 0 0", busy_a, done_a);
    end
    repeat (10) cycle();
    checks++;
    if (pop_cnt[0] - base_pop != 1) begin
      errors++;
      $display("FAIL single_pop_count: %0d pops, required 1", pop_cnt[0] - base_pop);
    end
  endtask

  task automatic test_back_to_back();
    int base_done;
    bit ok;
    popq_a.delete();
    base_done = done_cnt[0];
    tick();
    push_a(8'h00);
    push_a(8'hFF);
    push_a(8'h55);
    drive_fifo();
    sample();
    run_until_done(0, base_done + 3, 3 * 41 + 20, ok);
    checks++;
    if (!ok || popq_a.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: %0d pops %0d frames, required 3 3", popq_a.size(), done_cnt[0] - base_done);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (popq_a[i] - popq_a[i - 1] != 41) begin
          errors++;
          $display("FAIL b2b_spacing_%0d: %0d cycles, required 41", i, popq_a[i] - popq_a[i - 1]);
        end
      end
    end
    cycle();
    if (popq_a.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (bsh[0][(popq_a[i] - 1) & M] !== 1'b1 || bsh[0][popq_a[i] & M] !== 1'b0 ||
            bsh[0][(popq_a[i] + 1) & M] !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy_gap_%0d: busy %b%b%b, required 101", i,
                   bsh[0][(popq_a[i] - 1) & M], bsh[0][popq_a[i] & M], bsh[0][(popq_a[i] + 1) & M]);
        end
      end
    end
  endtask

  task automatic test_two_stop_bits();
    int t;
    int base_done;
    int high;
    bit ok;
    popq_b.delete();
    base_done = done_cnt[1];
    tick();
    push_b(8'h81);
    push_b(8'h3C);
    drive_fifo();
    sample();
    t = cyc;
    run_until_done(1, base_done + 1, 50, ok);
    checks++;
    if (!ok || last_done[1] - t != 33) begin
      errors++;
      $display("FAIL two_stop_length: done at T+%0d ok=%0d, required T+33", last_done[1] - t, ok);
    end
    high = 0;
    for (int c = t + 28; c <= t + 33; c++) if (txh[1][c & M] === 1'b1) high++;
    checks++;
    if (high != 6) begin
      errors++;
      $display("FAIL two_stop_high: %0d high cycles, required 6", high);
    end
    run_until_done(1, base_done + 2, 50, ok);
    checks++;
    if (!ok || popq_b.size() != 2 || popq_b[1] - popq_b[0] != 34) begin
      errors++;
      $display("FAIL two_stop_next_pop: %0d pops, spacing %0d, required 2 34", popq_b.size(),
               (popq_b.size() == 2) ? popq_b[1] - popq_b[0] : -1);
    end
  endtask

  task automatic test_enable_gating();
    int t;
    int base_done;
    int base_pop;
    int bad = 0;
    bit ok;
    base_done = done_cnt[0];
    tick();
    push_a(8'h3C);
    push_a(8'hC3);
    push_a(8'h99);
    drive_fifo();
    sample();
    t = cyc;
    while (cyc < t + 9) cycle();
    tick();
    tx_en = 1'b0;
    sample();
    run_until_done(0, base_done + 1, 50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gate_frame_timeout: done count %0d, required %0d", done_cnt[0], base_done + 1);
    end
    base_pop = pop_cnt[0];
    repeat (20) begin
      cycle();
      if (pop_a !== 1'b0 || busy_a !== 1'b0 || tx_a !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || pop_cnt[0] != base_pop || fq_a.size() != 2) begin
      errors++;
      $display("FAIL gate_hold: %0d bad cycles, %0d pops, fifo %0d, required 0 0 2", bad,
               pop_cnt[0] - base_pop, fq_a.size());
    end
    tick();
    tx_en = 1'b1;
    sample();
    checks++;
    if (pop_a !== 1'b1) begin
      errors++;
      $display("FAIL gate_reenable_pop: pop=%b, required 1", pop_a);
    end
    run_until_done(0, base_done + 3, 2 * 41 + 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gate_resume_timeout: done count %0d, required %0d", done_cnt[0], base_done + 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t;
    int base_done;
    bit ok;
    tick();
    push_a(8'h65);
    push_a(8'h2D);
    drive_fifo();
    sample();
    t = cyc;
    while (cyc < t + 17) cycle();
    tick();
    checks++;
    if (tx_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_line: tx=%b busy=%b, required 0 1", tx_a, busy_a);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || pop_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: tx=%b busy=%b pop=%b done=%b, required 1 0 0 0", tx_a, busy_a, pop_a, done_a);
    end
    void'(exp_a.pop_front());
    base_done = done_cnt[0];
    sample();
    repeat (3) cycle();
    checks++;
    if (done_cnt[0] != base_done || tx_a !== 1'b1 || pop_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: %0d dones tx=%b pop=%b, required 0 1 0", done_cnt[0] - base_done, tx_a, pop_a);
    end
    tick();
    reset = 1'b0;
    sample();
    run_until_done(0, base_done + 1, 60, ok);
    repeat (5) cycle();
    checks++;
    if (!ok || done_cnt[0] != base_done + 1) begin
      errors++;
      $display("FAIL reset_recover: %0d frames, required 1", done_cnt[0] - base_done);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      pop_cnt[u] = 0;
      done_cnt[u] = 0;
      last_pop[u] = -1000;
      last_done[u] = -1000;
      pop_prev[u] = 1'b0;
    end
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_two_stop_bits();
    test_enable_gating();
    test_reset_mid_frame();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0 || fq_a.size() != 0 || fq_b.size() != 0) begin
      errors++;
      $display("FAIL drain: expected left %0d/%0d fifo left %0d/%0d, required all 0",
               exp_a.size(), exp_b.size(), fq_a.size(), fq_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
